// File: rtl/gc_ramp_gen_pkg.sv
// gc_ramp_gen_pkg
// Shared definitions for the Gray-coded ramp generator: the state encoding
// used by the controller and a binary-to-Gray helper.
//
// The helper works on a fixed 64-bit container so that a single function can
// serve any lane width up to 64 bits. Callers widen their operand on the way
// in and truncate the result on the way out. The upper bit of a narrower lane
// is XORed with a zero, which is exactly the Gray rule for the lane's top bit.
package gc_ramp_gen_pkg;

    // Controller states; the state register is one bit wide.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Widest lane the Gray helper can encode.
    localparam int GC_MAX_WIDTH = 64;

    // Binary to Gray: g = b ^ (b >> 1)
    function automatic logic [GC_MAX_WIDTH-1:0] bin2gray(input logic [GC_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gc_ramp_gen_bin2gc.sv
// bin2gc
// Combinational per-lane encoder: converts one binary sample into its Gray code.
//
// Parameters:
//   DATA_WIDTH  bits per sample (at most GC_MAX_WIDTH)
// Ports:
//   bin  in   DATA_WIDTH  binary sample
//   gc   out  DATA_WIDTH  Gray-coded sample
module bin2gc
    import gc_ramp_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] bin,
    output logic [DATA_WIDTH-1:0] gc
);

    // Widen into the package helper's container, then keep only this lane's bits.
    assign gc = DATA_WIDTH'(bin2gray(GC_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gc_ramp_gen.sv
// gc_ramp_gen
// Burst generator that produces a linear ramp of samples. The samples are
// packed SAMPLES lanes per word, and each lane is Gray-coded. Lane k of word w
// carries gray(seed + (w*SAMPLES + k)*step). The sum wraps modulo
// 2^DATA_WIDTH. Words leave through a registered valid/ready interface.
//
// Optional feature (macro GC_RAMP_GEN_PARITY_EN): adds the gc_parity output,
// which holds one even-parity bit per Gray lane. It is registered alongside
// gc_data.
//
// Parameters:
//   DATA_WIDTH  bits per sample
//   SAMPLES     lanes per output word
//   CNT_WIDTH   width of the burst-length / word counter
// Ports:
//   clk        in   1                    clock
//   rst        in   1                    synchronous active-high reset
//   start      in   1                    begin a burst (sampled in IDLE only)
//   abort      in   1                    end the current burst at once, with no done pulse
//   num_words  in   CNT_WIDTH            burst length in words, sampled on start
//   seed       in   DATA_WIDTH           binary value of lane 0 of word 0
//   step       in   DATA_WIDTH           binary increment between adjacent samples
//   gc_data    out  SAMPLES*DATA_WIDTH   Gray lanes; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gc_valid   out  1                    gc_data holds a word
//   gc_ready   in   1                    sink accepts the current word
//   busy       out  1                    controller is not idle
//   done       out  1                    one-cycle pulse after the last word of a burst transfers
//   gc_parity  out  SAMPLES              (GC_RAMP_GEN_PARITY_EN only) per-lane XOR of gc_data
module gc_ramp_gen
    import gc_ramp_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLES    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CNT_WIDTH-1:0]          num_words,
    input  logic [DATA_WIDTH-1:0]         seed,
    input  logic [DATA_WIDTH-1:0]         step,
    output logic [SAMPLES*DATA_WIDTH-1:0] gc_data,
    output logic                          gc_valid,
    input  logic                          gc_ready,
    output logic                          busy,
    output logic                          done
`ifdef GC_RAMP_GEN_PARITY_EN
    ,
    output logic [SAMPLES-1:0]            gc_parity
`endif
);

    logic [0:0]                    state;
    logic [CNT_WIDTH-1:0]          word_cnt;
    logic [CNT_WIDTH-1:0]          last_idx;
    logic [DATA_WIDTH-1:0]         base_q;
    logic [DATA_WIDTH-1:0]         step_q;
    logic [DATA_WIDTH-1:0]         base_sel;
    logic [DATA_WIDTH-1:0]         step_sel;
    logic [DATA_WIDTH-1:0]         lane_bin [SAMPLES];
    logic [DATA_WIDTH-1:0]         lane_gc  [SAMPLES];
    logic [SAMPLES*DATA_WIDTH-1:0] next_data;
    logic                          start_ok;
    logic                          load_first;
    logic                          xfer;
    logic                          last_word;
    logic                          load_next;

    // An abort always wins over a start, so a start only counts in IDLE with no abort.
    // word_cnt is the index of the word on gc_data. The last word is the one
    // whose index equals num_words-1, as captured when the burst began.
    assign start_ok   = (state == ST_IDLE) && start && !abort;
    assign load_first = start_ok && (num_words != '0);
    assign xfer       = gc_valid && gc_ready;
    assign last_word  = (word_cnt == last_idx);
    assign load_next  = (state == ST_RUN) && !abort && xfer && !last_word;
    assign busy       = (state != ST_IDLE);

    // Pick the base for the next word to encode.
    // At burst start this is the fresh seed and step.
    // Otherwise the base advances by SAMPLES steps from the word just accepted.
    // Only the stored step is used in that case, so changes on the step
    // input during a burst have no effect.
    always_comb begin
        base_sel = base_q + step_q * DATA_WIDTH'(SAMPLES);
        step_sel = step_q;
        if (load_first) begin
            base_sel = seed;
            step_sel = step;
        end
    end

    // One encoder per lane.
    // Lane k holds base + k*step. Truncating to DATA_WIDTH makes the
    // sequence wrap without a discontinuity.
    for (genvar k = 0; k < SAMPLES; k++) begin : g_lane
        assign lane_bin[k] = base_sel + step_sel * DATA_WIDTH'(k);

        bin2gc #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_bin2gc (
            .bin(lane_bin[k]),
            .gc (lane_gc[k])
        );

        assign next_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_gc[k];
    end

    // Controller and output registers.
    // gc_data and gc_valid change only here, so gc_ready has no
    // combinational path to any output. A stalled word holds because nothing
    // is loaded until it transfers. In RUN, an abort is checked before the
    // transfer, so it beats a simultaneous handshake and suppresses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gc_valid <= 1'b0;
            gc_data  <= '0;
            done     <= 1'b0;
            word_cnt <= '0;
            last_idx <= '0;
            base_q   <= '0;
            step_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_first) begin
                        state    <= ST_RUN;
                        gc_valid <= 1'b1;
                        gc_data  <= next_data;
                        base_q   <= base_sel;
                        step_q   <= step_sel;
                        word_cnt <= '0;
                        last_idx <= num_words - 1'b1;
                    end else if (start_ok) begin
                        done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        gc_valid <= 1'b0;
                    end else if (xfer && last_word) begin
                        state    <= ST_IDLE;
                        gc_valid <= 1'b0;
                        done     <= 1'b1;
                    end else if (load_next) begin
                        gc_data  <= next_data;
                        base_q   <= base_sel;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gc_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef GC_RAMP_GEN_PARITY_EN
    logic [SAMPLES-1:0] next_parity;

    // Per-lane even parity of the Gray word about to be loaded.
    for (genvar p = 0; p < SAMPLES; p++) begin : g_parity
        assign next_parity[p] = ^lane_gc[p];
    end

    // Parity loads on exactly the same events as gc_data, so the two stay
    // aligned through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            gc_parity <= '0;
        end else if (load_first || load_next) begin
            gc_parity <= next_parity;
        end
    end
`endif

endmodule
